// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer types, response codes,
// word transfer size and the slave interface FSM states.
package ahb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } state_t;

  function automatic logic is_active(input htrans_t t);
    return (t == HT_NONSEQ) || (t == HT_SEQ);
  endfunction

endpackage

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave to register-file bridge: one wait state (SETUP) then a
// data phase (ACCESS) that drives rd_en/wr_en to the backend and stalls
// on backend ready; a registered backend error gives a two-cycle ERROR.
// Ports: clk, rst (sync, active high); AHB-Lite HSEL/HADDR/HTRANS/
// HWRITE/HSIZE/HWDATA/HREADY in, HRDATA/HREADYOUT/HRESP out; backend
// rd_en/wr_en/address(word index)/wr_data out, rd_data/ready/error in.
// Option: define AHB_SLV_SIZE_CHECK_EN to reject non-word or unaligned
// transfers locally (ERROR response, no backend access).
module ahb_slave_if
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic                  rd_en,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  ready,
  input  logic                  error
);

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] haddr_q;
  logic                  hwrite_q;
  logic [2:0]            hsize_q;

  logic accept;
  logic bad_req;
  logic take;
  logic unused_bits;

  assign accept = HSEL && HREADY && is_active(htrans_t'(HTRANS));

`ifdef AHB_SLV_SIZE_CHECK_EN
  assign bad_req = (HSIZE != HSIZE_WORD) || (HADDR[1:0] != 2'b00);
`else
  assign bad_req = 1'b0;
`endif

  // Size is captured for completeness but only consulted at accept time.
  assign unused_bits = ^{hsize_q, HSIZE, haddr_q[1:0]};

  // Only latch a new address phase in a cycle where this slave is ready,
  // otherwise the transfer in flight would lose its address.
  assign take = accept && HREADYOUT;

  assign address = haddr_q >> 2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      if (take) begin
        haddr_q  <= HADDR;
        hwrite_q <= HWRITE;
        hsize_q  <= HSIZE;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    HRDATA    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = bad_req ? S_ERR1 : S_SETUP;
      end
      S_SETUP: begin
        HREADYOUT = 1'b0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (error) begin
          HREADYOUT = 1'b0;
          HRESP     = HRESP_ERROR;
          state_d   = S_ERR2;
        end else begin
          wr_en     = hwrite_q;
          rd_en     = !hwrite_q;
          HREADYOUT = ready;
          if (hwrite_q) wr_data = HWDATA;
          if (!hwrite_q && ready) HRDATA = rd_data;
          if (ready) begin
            if (accept) state_d = bad_req ? S_ERR1 : S_SETUP;
            else state_d = S_IDLE;
          end
        end
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = S_ERR2;
      end
      S_ERR2: begin
        HRESP = HRESP_ERROR;
        if (accept) state_d = bad_req ? S_ERR1 : S_SETUP;
        else state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed bench for ahb_slave_if with a 16-word register-file backend
// whose range error is registered one cycle after the address.
module tb_ahb_slave_if;
  import ahb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ready;
  logic        error;

  logic [31:0] mem [16];
  logic        err_q;
  logic        be_ready;

  int errors = 0;
  int checks = 0;

  ahb_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .wr_data(wr_data), .rd_data(rd_data), .ready(ready),
    .error(error)
  );

  always #5 clk = ~clk;

  assign rd_data = (address < 32'd16) ? mem[address[3:0]] : 32'h0;
  assign ready   = be_ready;
  assign error   = err_q;

  always @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else begin
      err_q <= (address >= 32'd16);
      if (wr_en && ready && address < 32'd16)
        mem[address[3:0]] <= wr_data;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (rd_en && wr_en) begin
        errors++;
        $display("FAIL strobe_excl: rd_en=%b wr_en=%b want not both",
                 rd_en, wr_en);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sel, input logic [1:0] tr,
                       input logic [31:0] a, input logic w,
                       input logic [2:0] sz);
    HSEL   = sel;
    HTRANS = tr;
    HADDR  = a;
    HWRITE = w;
    HSIZE  = sz;
    HREADY = 1'b1;
  endtask

  task automatic bus_idle;
    drive(1'b0, HT_IDLE, 32'h0, 1'b0, HSIZE_WORD);
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    be_ready = 1'b1;
    HWDATA   = 32'h0;
    bus_idle();
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp: hreadyout=%b hresp=%b want 1 0",
               HREADYOUT, HRESP);
    end
    checks++;
    if (rd_en !== 1'b0 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: rd=%b wr=%b want 0 0", rd_en, wr_en);
    end
    checks++;
    if (address !== 32'h0 || wr_data !== 32'h0 || HRDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_buses: addr=%h wdata=%h rdata=%h want 0",
               address, wr_data, HRDATA);
    end
    tick();
  endtask

  task automatic test_write_read;
    drive(1'b1, HT_NONSEQ, 32'h08, 1'b1, HSIZE_WORD);
    @(negedge clk);
    checks++;
    if (HREADYOUT !== 1'b1) begin
      errors++;
      $display("FAIL wr_addr_phase: hreadyout=%b want 1", HREADYOUT);
    end
    tick();
    bus_idle();
    HWDATA = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (HREADYOUT !== 1'b0 || wr_en !== 1'b0 || address !== 32'd2) begin
      errors++;
      $display("FAIL wr_setup: hready=%b wr=%b addr=%h want 0 0 2",
               HREADYOUT, wr_en, address);
    end
    tick();
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || rd_en !== 1'b0 || address !== 32'd2 ||
        wr_data !== 32'hDEADBEEF || HREADYOUT !== 1'b1 || HRESP !== 1'b0)
    begin
      errors++;
      $display("FAIL wr_access: wr=%b rd=%b addr=%h wd=%h hr=%b resp=%b want 1 0 2 deadbeef 1 0",
               wr_en, rd_en, address, wr_data, HREADYOUT, HRESP);
    end
    tick();
    HWDATA = 32'h0;
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b0 || mem[2] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_done: wr=%b mem2=%h want 0 deadbeef",
               wr_en, mem[2]);
    end
    tick();
    drive(1'b1, HT_NONSEQ, 32'h08, 1'b0, HSIZE_WORD);
    tick();
    bus_idle();
    @(negedge clk);
    checks++;
    if (rd_en !== 1'b0 || HRDATA !== 32'h0) begin
      errors++;
      $display("FAIL rd_setup: rd=%b rdata=%h want 0 0", rd_en, HRDATA);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rd_en !== 1'b1 || HRDATA !== 32'hDEADBEEF || HRESP !== 1'b0 ||
        HREADYOUT !== 1'b1) begin
      errors++;
      $display("FAIL rd_access: rd=%b rdata=%h resp=%b hr=%b want 1 deadbeef 0 1",
               rd_en, HRDATA, HRESP, HREADYOUT);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    drive(1'b1, HT_NONSEQ, 32'h0C, 1'b1, HSIZE_WORD);
    tick();
    bus_idle();
    HWDATA = 32'hCAFEF00D;
    tick();
    drive(1'b1, HT_NONSEQ, 32'h0C, 1'b0, HSIZE_WORD);
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || HREADYOUT !== 1'b1 || wr_data !== 32'hCAFEF00D)
    begin
      errors++;
      $display("FAIL b2b_wr: wr=%b hr=%b wd=%h want 1 1 cafef00d",
               wr_en, HREADYOUT, wr_data);
    end
    tick();
    bus_idle();
    HWDATA = 32'h0;
    @(negedge clk);
    checks++;
    if (HREADYOUT !== 1'b0 || address !== 32'd3 || rd_en !== 1'b0 ||
        wr_en !== 1'b0) begin
      errors++;
      $display("FAIL b2b_setup: hr=%b addr=%h rd=%b wr=%b want 0 3 0 0",
               HREADYOUT, address, rd_en, wr_en);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rd_en !== 1'b1 || HRDATA !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL b2b_rd: rd=%b rdata=%h want 1 cafef00d",
               rd_en, HRDATA);
    end
    tick();
  endtask

  task automatic test_error;
    drive(1'b1, HT_NONSEQ, 32'h40, 1'b1, HSIZE_WORD);
    tick();
    bus_idle();
    HWDATA = 32'h12345678;
    @(negedge clk);
    checks++;
    if (address !== 32'd16 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL err_setup: addr=%h wr=%b want 10 0", address, wr_en);
    end
    tick();
    @(negedge clk);
    checks++;
    if (HREADYOUT !== 1'b0 || HRESP !== 1'b1 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL err_cycle1: hr=%b resp=%b wr=%b want 0 1 0",
               HREADYOUT, HRESP, wr_en);
    end
    tick();
    @(negedge clk);
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b1 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL err_cycle2: hr=%b resp=%b wr=%b want 1 1 0",
               HREADYOUT, HRESP, wr_en);
    end
    tick();
    HWDATA = 32'h0;
    @(negedge clk);
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
      errors++;
      $display("FAIL err_recover: hr=%b resp=%b want 1 0",
               HREADYOUT, HRESP);
    end
    tick();
  endtask

  task automatic test_size;
    drive(1'b1, HT_NONSEQ, 32'h04, 1'b1, 3'b000);
    tick();
    bus_idle();
    HWDATA = 32'h11223344;
`ifdef AHB_SLV_SIZE_CHECK_EN
    @(negedge clk);
    checks++;
    if (HREADYOUT !== 1'b0 || HRESP !== 1'b1 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL size_err1: hr=%b resp=%b wr=%b want 0 1 0",
               HREADYOUT, HRESP, wr_en);
    end
    tick();
    @(negedge clk);
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b1 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL size_err2: hr=%b resp=%b wr=%b want 1 1 0",
               HREADYOUT, HRESP, wr_en);
    end
    tick();
    HWDATA = 32'h0;
    @(negedge clk);
    checks++;
    if (mem[1] !== 32'h0 || HRESP !== 1'b0) begin
      errors++;
      $display("FAIL size_nowrite: mem1=%h resp=%b want 0 0",
               mem[1], HRESP);
    end
`else
    @(negedge clk);
    checks++;
    if (HREADYOUT !== 1'b0 || HRESP !== 1'b0) begin
      errors++;
      $display("FAIL size_setup: hr=%b resp=%b want 0 0",
               HREADYOUT, HRESP);
    end
    tick();
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || address !== 32'd1 || HRESP !== 1'b0) begin
      errors++;
      $display("FAIL size_access: wr=%b addr=%h resp=%b want 1 1 0",
               wr_en, address, HRESP);
    end
    tick();
    HWDATA = 32'h0;
    @(negedge clk);
    checks++;
    if (mem[1] !== 32'h11223344) begin
      errors++;
      $display("FAIL size_write: mem1=%h want 11223344", mem[1]);
    end
`endif
    tick();
  endtask

  task automatic test_no_transfer;
    logic [1:0] tr_tab [4];
    logic       sel_tab [4];
    logic       rdy_tab [4];
    tr_tab  = '{HT_IDLE, HT_BUSY, HT_NONSEQ, HT_NONSEQ};
    sel_tab = '{1'b1, 1'b1, 1'b0, 1'b1};
    rdy_tab = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int p = 0; p < 4; p++) begin
      drive(sel_tab[p], tr_tab[p], 32'h08, 1'b1, HSIZE_WORD);
      HREADY = rdy_tab[p];
      HWDATA = 32'h55AA55AA;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        checks++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || rd_en !== 1'b0 ||
            wr_en !== 1'b0) begin
          errors++;
          $display("FAIL no_xfer p%0d c%0d: hr=%b resp=%b rd=%b wr=%b want 1 0 0 0",
                   p, c, HREADYOUT, HRESP, rd_en, wr_en);
        end
        tick();
        bus_idle();
      end
    end
    HWDATA = 32'h0;
  endtask

  task automatic test_stall_reset;
    drive(1'b1, HT_NONSEQ, 32'h10, 1'b1, HSIZE_WORD);
    tick();
    bus_idle();
    HWDATA   = 32'hA5A5A5A5;
    be_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (HREADYOUT !== 1'b0 || wr_en !== 1'b1 || address !== 32'd4) begin
        errors++;
        $display("FAIL stall_%0d: hr=%b wr=%b addr=%h want 0 1 4",
                 i, HREADYOUT, wr_en, address);
      end
      tick();
    end
    be_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (HREADYOUT !== 1'b1 || wr_en !== 1'b1 || mem[4] !== 32'h0) begin
      errors++;
      $display("FAIL stall_release: hr=%b wr=%b mem4=%h want 1 1 0",
               HREADYOUT, wr_en, mem[4]);
    end
    tick();
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b0 || mem[4] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL stall_done: wr=%b mem4=%h want 0 a5a5a5a5",
               wr_en, mem[4]);
    end
    tick();
    drive(1'b1, HT_NONSEQ, 32'h14, 1'b1, HSIZE_WORD);
    tick();
    bus_idle();
    HWDATA   = 32'h5A5A5A5A;
    be_ready = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: wr=%b want 1", wr_en);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b0 || HREADYOUT !== 1'b1 || address !== 32'h0 ||
        wr_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid: wr=%b hr=%b addr=%h wd=%h want 0 1 0 0",
               wr_en, HREADYOUT, address, wr_data);
    end
    tick();
    be_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b0 || rd_en !== 1'b0 || mem[5] !== 32'h0) begin
      errors++;
      $display("FAIL rst_after: wr=%b rd=%b mem5=%h want 0 0 0",
               wr_en, rd_en, mem[5]);
    end
    tick();
    HWDATA = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_error();
    test_size();
    test_no_transfer();
    test_stall_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
